instruction_decode_stage: RTL and testbench
===========================================

// Module: instruction_decode_stage
// PURPOSE
//  Registered RV32I decode stage between fetch and execute of the pipelined core.
//  Splits ILEN-bit instruction bits into opcode, register indices, funct fields and a format-selected sign-extended immediate.
//  Flags illegal encodings and optionally accepts the M extension.
//  Decoupled by valid/ready on both sides, with an optional 2-entry skid buffer and a synchronous flush for branch redirects.
// PARAMETERS
//  XLEN      32  datapath / immediate width (>= 32)
//  ILEN      32  instruction width (fixed 32; compressed instructions not supported)
//  ENABLE_M  0   1: funct7=7'h01 under OP decodes as legal MUL/DIV family
//  SKID      1   1: 2-entry skid buffer, in_ready registered; 0: 1 entry, in_ready combinational
// PORTS
//  clock        in   1     rising-edge clock
//  reset_n      in   1     asynchronous, active-low reset
//  flush        in   1     sync: discard all held and incoming instructions this cycle
//  in_valid     in   1     fetch presents instruction
//  in_ready     out  1     stage accepts instruction this cycle
//  in_instr     in   ILEN  raw instruction bits
//  in_pc        in   XLEN  PC of in_instr
//  out_valid    out  1     decoded instruction available
//  out_ready    in   1     execute accepts decoded instruction
//  out_pc       out  XLEN  PC passthrough
//  out_opcode   out  7     instr[6:0] (opcode_t)
//  out_rd/rs1/rs2 out 5    instr[11:7] / [19:15] / [24:20], raw, regardless of format
//  out_funct3   out  3     instr[14:12]
//  out_funct7   out  7     instr[31:25]
//  out_imm      out  XLEN  sign-extended immediate per format; 0 for R-type
//  out_illegal  out  1     encoding illegal (instruction still delivered, execute traps)
// BEHAVIOUR
//  Reset (reset_n=0, async): state EMPTY; out_valid=0; in_ready=1; all out_* data regs = 0.
//  Transfer on valid&&ready on each side. Decode is combinational on in_instr; results are registered on accept.
//  Latency: 1 cycle, accept at edge N -> out_valid=1 after edge N.
//  Immediate formats (all sign-extended from instr[31]):
//   I (LOAD, OP_IMM, JALR): instr[31:20]
//   S (STORE): {instr[31:25], instr[11:7]}
//   B (BRANCH): {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}
//   U (LUI, AUIPC): {instr[31:12], 12'b0}
//   J (JAL): {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}
//  out_illegal=1 if any of:
//   - instr[1:0] != 2'b11
//   - opcode not in {LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP_IMM, OP, MISC_MEM, SYSTEM}
//   - BRANCH funct3 in {2,3}; LOAD funct3 in {3,6,7}; STORE funct3 > 2; JALR funct3 != 0
//   - OP funct7 not in {00, 20}, except 01 legal iff ENABLE_M
//   - OP funct7=20 with funct3 not in {0,5}
//   - OP_IMM shift (funct3 1/5): funct7 not 00 (or 20 for funct3=5)
//  Illegal encodings set out_illegal=1 and out_imm=0.
//  SKID=0 state machine: EMPTY/FULL. in_ready = !out_valid || out_ready (one combinational path).
//  SKID=1 state machine: EMPTY -> ONE on accept.
//   ONE: out_ready && in_valid stays ONE; out_ready only goes EMPTY; in_valid only (stalled) goes TWO, capturing into skid reg.
//   TWO: in_ready=0; on out_ready the skid reg moves to the output reg -> ONE.
//   in_ready = (state != TWO), registered; no combinational in->out ready path.
//  Ordering: strictly FIFO. No instruction is dropped or duplicated except by flush.
//  Output stability: out_* held stable while out_valid && !out_ready.
//  flush=1: next state EMPTY, out_valid=0, any in_valid that cycle is discarded; in_ready=1 next cycle.
//   Flush wins over simultaneous accept and drain. Data regs are not cleared.
//  Reset asserted mid-stream: immediately EMPTY; no held instruction survives.
// TESTING
//  1 in 32'h010cc783 pc 0x80 -> opcode LOAD, rd 15, rs1 25, funct3 4, imm 0x10, pc 0x80, illegal 0, one cycle later.
//  2 formats: 02912a23 -> imm 0x34, rs1 2, rs2 9; fc010113 -> imm 0xFFFFFFC0;
//    fed79ce3 -> imm 0xFFFFFFF8, funct3 1; 00001717 -> rd 14, imm 0x1000; 00001cb7 -> rd 25, imm 0x1000.
//  3 ENABLE_M=0: 02b50533 (mul) -> illegal 1; ENABLE_M=1 -> illegal 0, funct7 0x01; 00000000 -> illegal 1.
//  4 backpressure SKID=1: stream 4 instrs with out_ready=0 -> in_ready low after 2 accepted;
//    release -> all 4 delivered in order, outputs stable while stalled.
//  5 flush while TWO with in_valid=1 -> next cycle out_valid=0, in_ready=1; flushed/incoming instrs never appear.
//  6 reset_n low mid-stream (async, between edges) -> out_valid=0 immediately; first post-reset instr decodes correctly.

Source files
------------

// File: rtl/instruction_decode_stage_if.sv
// Handshake bundle between fetch, the decode stage and execute.
//   in_valid/in_ready/in_instr/in_pc : fetch -> decode request channel
//   out_valid/out_ready/out_*         : decode -> execute decoded-instruction channel
// Modports:
//   slave  : the decode stage's view (consumes in_*, produces out_*)
//   master : the environment's view (drives in_* and out_ready)
interface instruction_decode_stage_if #(
    parameter int XLEN = 32,
    parameter int ILEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [ILEN-1:0] in_instr;
    logic [XLEN-1:0] in_pc;

    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [6:0]      out_opcode;
    logic [4:0]      out_rd;
    logic [4:0]      out_rs1;
    logic [4:0]      out_rs2;
    logic [2:0]      out_funct3;
    logic [6:0]      out_funct7;
    logic [XLEN-1:0] out_imm;
    logic            out_illegal;

    modport slave (
        input  in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_pc, out_opcode, out_rd, out_rs1, out_rs2,
               out_funct3, out_funct7, out_imm, out_illegal
    );

    modport master (
        output in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_pc, out_opcode, out_rd, out_rs1, out_rs2,
               out_funct3, out_funct7, out_imm, out_illegal
    );
endinterface

// File: rtl/instruction_decode_stage.sv
// Registered RV32I decode stage between fetch and execute.
// Splits the instruction into opcode / register indices / funct fields, builds the
// format-selected sign-extended immediate and flags illegal encodings (optionally
// accepting the M extension). Valid/ready on both sides; SKID=1 gives a 2-entry
// skid buffer with a registered in_ready, SKID=0 a single entry with a
// combinational in_ready. flush drops everything held and incoming in one cycle.
// Ports:
//   clock    : rising-edge clock
//   reset_n  : asynchronous active-low reset
//   flush    : synchronous discard of held and incoming instructions
//   bus      : instruction_decode_stage_if.slave (in_* request, out_* decoded result)
module instruction_decode_stage #(
    parameter int XLEN     = 32,
    parameter int ILEN     = 32,
    parameter int ENABLE_M = 0,
    parameter int SKID     = 1
) (
    input logic                        clock,
    input logic                        reset_n,
    input logic                        flush,
    instruction_decode_stage_if.slave  bus
);

    typedef enum logic [6:0] {
        OPC_LUI      = 7'b0110111,
        OPC_AUIPC    = 7'b0010111,
        OPC_JAL      = 7'b1101111,
        OPC_JALR     = 7'b1100111,
        OPC_BRANCH   = 7'b1100011,
        OPC_LOAD     = 7'b0000011,
        OPC_STORE    = 7'b0100011,
        OPC_OP_IMM   = 7'b0010011,
        OPC_OP       = 7'b0110011,
        OPC_MISC_MEM = 7'b0001111,
        OPC_SYSTEM   = 7'b1110011
    } opcode_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [6:0]      opcode;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [2:0]      funct3;
        logic [6:0]      funct7;
        logic [XLEN-1:0] imm;
        logic            illegal;
    } dec_t;

    typedef enum logic [1:0] {S_EMPTY, S_ONE, S_TWO} state_t;

    // ------------------------------------------------------------------
    // Combinational decode of the incoming instruction
    // ------------------------------------------------------------------
    logic [31:0] instr;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm32;
    logic        illegal;
    dec_t        dec;

    assign instr = bus.in_instr[31:0];
    assign f3    = instr[14:12];
    assign f7    = instr[31:25];

    always_comb begin
        imm32   = '0;
        illegal = 1'b0;
        case (instr[6:0])
            OPC_LUI, OPC_AUIPC: imm32 = {instr[31:12], 12'b0};
            OPC_JAL:  imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                               instr[30:21], 1'b0};
            OPC_JALR: begin
                imm32   = {{20{instr[31]}}, instr[31:20]};
                illegal = (f3 != 3'd0);
            end
            OPC_BRANCH: begin
                imm32   = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                           instr[11:8], 1'b0};
                illegal = (f3[2:1] == 2'b01);            // funct3 2 or 3
            end
            OPC_LOAD: begin
                imm32   = {{20{instr[31]}}, instr[31:20]};
                illegal = (f3 == 3'd3) || (f3[2:1] == 2'b11);  // 3, 6, 7
            end
            OPC_STORE: begin
                imm32   = {{20{instr[31]}}, instr[31:25], instr[11:7]};
                illegal = (f3 > 3'd2);
            end
            OPC_OP_IMM: begin
                imm32 = {{20{instr[31]}}, instr[31:20]};
                // shifts carry a funct7 in the upper immediate bits
                if (f3 == 3'd1)
                    illegal = (f7 != 7'h00);
                else if (f3 == 3'd5)
                    illegal = (f7 != 7'h00) && (f7 != 7'h20);
            end
            OPC_OP: begin
                // R-type: no immediate
                case (f7)
                    7'h00:   illegal = 1'b0;
                    7'h20:   illegal = (f3 != 3'd0) && (f3 != 3'd5);
                    7'h01:   illegal = (ENABLE_M == 0);
                    default: illegal = 1'b1;
                endcase
            end
            OPC_MISC_MEM, OPC_SYSTEM: illegal = 1'b0;
            default: illegal = 1'b1;
        endcase
        // compressed / reserved quadrants never reach execute as legal
        if (instr[1:0] != 2'b11)
            illegal = 1'b1;

        dec.pc      = bus.in_pc;
        dec.opcode  = instr[6:0];
        dec.rd      = instr[11:7];
        dec.rs1     = instr[19:15];
        dec.rs2     = instr[24:20];
        dec.funct3  = f3;
        dec.funct7  = f7;
        dec.imm     = illegal ? '0 : XLEN'($signed(imm32));
        dec.illegal = illegal;
    end

    // ------------------------------------------------------------------
    // Occupancy control
    // ------------------------------------------------------------------
    state_t state_q, state_d;
    dec_t   out_q, out_d;
    dec_t   skid_q, skid_d;
    logic   in_ready_q;
    logic   in_ready;
    logic   out_valid;
    logic   accept;
    logic   drain;

    assign out_valid = (state_q != S_EMPTY);
    // SKID=1: ready comes straight from a flop so execute's out_ready never
    // reaches fetch combinationally. SKID=0 trades that for one entry.
    assign in_ready  = (SKID != 0) ? in_ready_q : (!out_valid || bus.out_ready);
    assign accept    = bus.in_valid && in_ready && !flush;
    assign drain     = out_valid && bus.out_ready;

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        skid_d  = skid_q;
        if (flush) begin
            // flush beats any same-cycle accept or drain; data regs keep contents
            state_d = S_EMPTY;
        end else begin
            case (state_q)
                S_EMPTY: begin
                    if (accept) begin
                        state_d = S_ONE;
                        out_d   = dec;
                    end
                end
                S_ONE: begin
                    if (accept && drain) begin
                        out_d = dec;
                    end else if (drain) begin
                        state_d = S_EMPTY;
                    end else if (accept) begin
                        // output stalled: park the newcomer behind it
                        state_d = S_TWO;
                        skid_d  = dec;
                    end
                end
                S_TWO: begin
                    if (drain) begin
                        state_d = S_ONE;
                        out_d   = skid_q;
                    end
                end
                default: state_d = S_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_EMPTY;
            in_ready_q <= 1'b1;
            out_q      <= '0;
            skid_q     <= '0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != S_TWO);
            out_q      <= out_d;
            skid_q     <= skid_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.in_ready    = in_ready;
    assign bus.out_valid   = out_valid;
    assign bus.out_pc      = out_q.pc;
    assign bus.out_opcode  = out_q.opcode;
    assign bus.out_rd      = out_q.rd;
    assign bus.out_rs1     = out_q.rs1;
    assign bus.out_rs2     = out_q.rs2;
    assign bus.out_funct3  = out_q.funct3;
    assign bus.out_funct7  = out_q.funct7;
    assign bus.out_imm     = out_q.imm;
    assign bus.out_illegal = out_q.illegal;

endmodule

// File: tb/tb_instruction_decode_stage.sv
module tb_instruction_decode_stage;

    typedef struct packed {
        logic [31:0] pc;
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
        logic        ill;
    } exp_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] imm;
        logic        ill0;
        logic        ill1;
    } dir_t;

    logic clock = 1'b0;
    logic reset_n;
    logic flush;
    logic rnd_ready = 1'b0;
    logic rdy_rand  = 1'b1;
    logic rdy_fixed = 1'b1;

    int checks = 0;
    int passes = 0;
    exp_t q1[$];
    exp_t q2[$];

    always #5 clock = ~clock;

    // dut : ENABLE_M=0, SKID=1 (fully exercised with backpressure)
    // dut2: ENABLE_M=1, SKID=0 fed with exactly what dut accepts, never stalled
    instruction_decode_stage_if #(.XLEN(32), .ILEN(32)) bus ();
    instruction_decode_stage_if #(.XLEN(32), .ILEN(32)) bus2 ();

    assign bus.out_ready  = rnd_ready ? rdy_rand : rdy_fixed;
    assign bus2.in_valid  = bus.in_valid && bus.in_ready && !flush;
    assign bus2.in_instr  = bus.in_instr;
    assign bus2.in_pc     = bus.in_pc;
    assign bus2.out_ready = 1'b1;

    instruction_decode_stage #(.XLEN(32), .ILEN(32), .ENABLE_M(0), .SKID(1)) dut (
        .clock(clock), .reset_n(reset_n), .flush(flush), .bus(bus));
    instruction_decode_stage #(.XLEN(32), .ILEN(32), .ENABLE_M(1), .SKID(0)) dut2 (
        .clock(clock), .reset_n(reset_n), .flush(flush), .bus(bus2));

    always @(posedge clock) begin
        #1;
        rdy_rand = ($urandom_range(0, 3) != 0);
    end

    // ---------------- reference model ----------------
    function automatic int sext(input int v, input int n);
        return v - (((v >> (n - 1)) & 1) * (1 << n));
    endfunction

    function automatic exp_t ref_decode(input logic [31:0] i, input logic [31:0] pc, input bit m_en);
        exp_t e;
        int f3, f7, imm;
        bit ok;
        f3 = int'(i[14:12]);
        f7 = int'(i[31:25]);
        e.pc = pc; e.op = i[6:0]; e.rd = i[11:7]; e.rs1 = i[19:15]; e.rs2 = i[24:20];
        e.f3 = i[14:12]; e.f7 = i[31:25];
        ok = 1; imm = 0;
        case (i[6:0])
            7'h37, 7'h17: imm = int'(i & 32'hFFFF_F000);
            7'h6f: imm = sext((int'(i[31]) << 20) + (int'(i[19:12]) << 12) +
                              (int'(i[20]) << 11) + (int'(i[30:21]) << 1), 21);
            7'h67: begin imm = sext(int'(i[31:20]), 12); ok = (f3 == 0); end
            7'h63: begin
                imm = sext((int'(i[31]) << 12) + (int'(i[7]) << 11) +
                           (int'(i[30:25]) << 5) + (int'(i[11:8]) << 1), 13);
                ok = !(f3 inside {2, 3});
            end
            7'h03: begin imm = sext(int'(i[31:20]), 12); ok = !(f3 inside {3, 6, 7}); end
            7'h23: begin imm = sext(int'(i[31:25]) * 32 + int'(i[11:7]), 12); ok = (f3 <= 2); end
            7'h13: begin
                imm = sext(int'(i[31:20]), 12);
                if (f3 == 1) ok = (f7 == 0);
                if (f3 == 5) ok = (f7 inside {0, 32});
            end
            7'h33: ok = (f7 == 0) || (f7 == 32 && f3 inside {0, 5}) || (f7 == 1 && m_en);
            7'h0f, 7'h73: ok = 1;
            default: ok = 0;
        endcase
        if (i[1:0] != 2'b11) ok = 0;
        e.ill = !ok;
        e.imm = ok ? 32'(imm) : 32'h0;
        return e;
    endfunction

    function automatic exp_t mk_exp(input logic [31:0] i, input logic [31:0] pc,
                                    input logic [31:0] imm, input logic ill);
        exp_t e;
        e.pc = pc; e.op = i[6:0]; e.rd = i[11:7]; e.rs1 = i[19:15]; e.rs2 = i[24:20];
        e.f3 = i[14:12]; e.f7 = i[31:25]; e.imm = imm; e.ill = ill;
        return e;
    endfunction

    function automatic exp_t snap1();
        return '{bus.out_pc, bus.out_opcode, bus.out_rd, bus.out_rs1, bus.out_rs2,
                 bus.out_funct3, bus.out_funct7, bus.out_imm, bus.out_illegal};
    endfunction

    function automatic exp_t snap2();
        return '{bus2.out_pc, bus2.out_opcode, bus2.out_rd, bus2.out_rs1, bus2.out_rs2,
                 bus2.out_funct3, bus2.out_funct7, bus2.out_imm, bus2.out_illegal};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic cmp(input string nm, input exp_t a, input exp_t e);
        checks++;
        if (a === e) passes++;
        else $display("FAIL %s: got pc=%h op=%h rd=%0d rs1=%0d rs2=%0d f3=%0d f7=%h imm=%h ill=%b expected pc=%h op=%h rd=%0d rs1=%0d rs2=%0d f3=%0d f7=%h imm=%h ill=%b",
                      nm, a.pc, a.op, a.rd, a.rs1, a.rs2, a.f3, a.f7, a.imm, a.ill,
                      e.pc, e.op, e.rd, e.rs1, e.rs2, e.f3, e.f7, e.imm, e.ill);
    endtask

    // ---------------- monitor ----------------
    bit   stall_v = 0;
    exp_t stall_snap;

    always @(negedge clock) begin
        exp_t e;
        if (!reset_n) begin
            stall_v = 0;
        end else begin
            if (stall_v) begin
                chk("stall_valid_held", 32'(bus.out_valid), 32'd1);
                cmp("stall_data_stable", snap1(), stall_snap);
            end
            if (bus.out_valid && bus.out_ready && !flush) begin
                if (q1.size() == 0) begin
                    checks++;
                    $display("FAIL dut_unexpected_output: got pc=%h expected none", bus.out_pc);
                end else begin
                    e = q1.pop_front();
                    cmp("dut_output", snap1(), e);
                end
            end
            stall_v    = bus.out_valid && !bus.out_ready && !flush;
            stall_snap = snap1();
            if (bus2.out_valid && !flush) begin
                if (q2.size() == 0) begin
                    checks++;
                    $display("FAIL dut2_unexpected_output: got pc=%h expected none", bus2.out_pc);
                end else begin
                    e = q2.pop_front();
                    cmp("dut2_output", snap2(), e);
                end
            end
        end
    end

    // ---------------- driver ----------------
    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [31:0] i, input logic [31:0] pc, input exp_t e1, input exp_t e2);
        bit done = 0;
        bus.in_valid = 1'b1; bus.in_instr = i; bus.in_pc = pc;
        for (int n = 0; n < 100 && !done; n++) begin
            @(negedge clock);
            if (bus.in_ready && !flush && reset_n) begin
                q1.push_back(e1);
                q2.push_back(e2);
                done = 1;
            end
            @(posedge clock); #1;
        end
        if (!done) begin
            checks++;
            $display("FAIL send_timeout: got no accept expected accept for pc=%h", pc);
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic send_rand(input logic [31:0] i, input logic [31:0] pc);
        send(i, pc, ref_decode(i, pc, 1'b0), ref_decode(i, pc, 1'b1));
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        repeat (n) begin @(posedge clock); #1; end
    endtask

    task automatic do_flush();
        flush = 1'b1;
        bus.in_valid = 1'($urandom_range(0, 1));
        bus.in_instr = $urandom; bus.in_pc = $urandom & ~32'h3;
        @(negedge clock);
        q1.delete(); q2.delete();
        @(posedge clock); #1;
        flush = 1'b0; bus.in_valid = 1'b0;
        @(negedge clock);
        chk("flush_out_valid", 32'(bus.out_valid), 32'd0);
        chk("flush_in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clock); #1;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] v;
        logic [6:0]  ops [11] = '{7'h37, 7'h17, 7'h6f, 7'h67, 7'h63, 7'h03,
                                  7'h23, 7'h13, 7'h33, 7'h0f, 7'h73};
        logic [6:0]  f7s [3] = '{7'h00, 7'h20, 7'h01};
        v = $urandom;
        if ($urandom_range(0, 7) != 0) v[6:0] = ops[$urandom_range(0, 10)];
        if ($urandom_range(0, 1) != 0) v[31:25] = f7s[$urandom_range(0, 2)];
        return v;
    endfunction

    dir_t dir [16] = '{
        '{32'h010cc783, 32'h00000010, 1'b0, 1'b0},
        '{32'h02912a23, 32'h00000034, 1'b0, 1'b0},
        '{32'hfc010113, 32'hFFFFFFC0, 1'b0, 1'b0},
        '{32'hfed79ce3, 32'hFFFFFFF8, 1'b0, 1'b0},
        '{32'h00001717, 32'h00001000, 1'b0, 1'b0},
        '{32'h00001cb7, 32'h00001000, 1'b0, 1'b0},
        '{32'h02b50533, 32'h00000000, 1'b1, 1'b0},
        '{32'h02b54533, 32'h00000000, 1'b1, 1'b0},
        '{32'h00000000, 32'h00000000, 1'b1, 1'b1},
        '{32'h40005013, 32'h00000400, 1'b0, 1'b0},
        '{32'h40001013, 32'h00000000, 1'b1, 1'b1},
        '{32'h40001033, 32'h00000000, 1'b1, 1'b1},
        '{32'h008000ef, 32'h00000008, 1'b0, 1'b0},
        '{32'h00003063, 32'h00000000, 1'b1, 1'b1},
        '{32'h00001067, 32'h00000000, 1'b1, 1'b1},
        '{32'h0000000f, 32'h00000000, 1'b0, 1'b0}
    };

    task automatic send_dir(input int k, input logic [31:0] pc);
        send(dir[k].instr, pc, mk_exp(dir[k].instr, pc, dir[k].imm, dir[k].ill0),
             mk_exp(dir[k].instr, pc, dir[k].imm, dir[k].ill1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; flush = 1'b0;
        bus.in_valid = 1'b0; bus.in_instr = '0; bus.in_pc = '0;
        #12;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_out_imm", bus.out_imm, 32'd0);
        chk("rst_out_pc", bus.out_pc, 32'd0);
        chk("rst_out_opcode", 32'(bus.out_opcode), 32'd0);
        chk("rst_out_illegal", 32'(bus.out_illegal), 32'd0);
        reset_n = 1'b1;
        @(posedge clock); #1;

        // latency: accept at edge N, valid right after N
        send_dir(0, 32'h80);
        @(negedge clock);
        chk("latency_out_valid", 32'(bus.out_valid), 32'd1);
        @(posedge clock); #1;

        // directed encodings, back to back
        for (int k = 1; k < 16; k++) send_dir(k, 32'h84 + 32'(k) * 4);
        idle(3);

        // backpressure into TWO
        rdy_fixed = 1'b0;
        send_rand(rand_instr(), 32'h200);
        send_rand(rand_instr(), 32'h204);
        bus.in_valid = 1'b1; bus.in_instr = 32'h02912a23; bus.in_pc = 32'h208;
        repeat (3) begin
            @(negedge clock);
            chk("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
            @(posedge clock); #1;
        end
        rdy_fixed = 1'b1;
        send_dir(1, 32'h208);
        send_dir(2, 32'h20c);
        idle(4);

        // flush while TWO with an incoming instruction
        rdy_fixed = 1'b0;
        send_rand(rand_instr(), 32'h300);
        send_rand(rand_instr(), 32'h304);
        flush = 1'b1; bus.in_valid = 1'b1; bus.in_instr = 32'hfc010113; bus.in_pc = 32'h308;
        @(negedge clock);
        q1.delete(); q2.delete();
        @(posedge clock); #1;
        flush = 1'b0; bus.in_valid = 1'b0;
        @(negedge clock);
        chk("flush_two_out_valid", 32'(bus.out_valid), 32'd0);
        chk("flush_two_in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clock); #1;
        rdy_fixed = 1'b1;
        send_dir(4, 32'h30c);
        idle(3);

        // async reset between edges while holding two entries
        rdy_fixed = 1'b0;
        send_rand(rand_instr(), 32'h400);
        send_rand(rand_instr(), 32'h404);
        #1;
        reset_n = 1'b0;
        #1;
        chk("async_rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("async_rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("async_rst_dut2_valid", 32'(bus2.out_valid), 32'd0);
        q1.delete(); q2.delete();
        @(negedge clock); #2;
        reset_n = 1'b1;
        @(posedge clock); #1;
        rdy_fixed = 1'b1;
        send_dir(0, 32'h80);
        idle(3);

        // randomized traffic with random backpressure and flushes
        rnd_ready = 1'b1;
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 24) == 0) do_flush();
            else begin
                send_rand(rand_instr(), $urandom & ~32'h3);
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
            end
        end
        rnd_ready = 1'b0; rdy_fixed = 1'b1;
        idle(1);
        for (int n = 0; n < 100 && (q1.size() != 0 || q2.size() != 0); n++) @(posedge clock);
        #1;
        chk("drain_dut_queue", 32'(q1.size()), 32'd0);
        chk("drain_dut2_queue", 32'(q2.size()), 32'd0);
        chk("final_out_valid", 32'(bus.out_valid), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
